// File: rtl/h264_inter_pkg.sv
// Shared types and constants for the H.264 inter-prediction SAD datapath.
// Partition index map matches the order the SAD adder tree emits its sums.
`default_nettype none

package h264_inter_pkg;

  localparam int NPART     = 41;
  localparam int SAD_WIDTH = 16;
  localparam int MV_WIDTH  = 6;

  typedef logic        [SAD_WIDTH-1:0] sad_t;
  typedef logic signed [MV_WIDTH-1:0]  mv_t;

  localparam sad_t SAD_MAX = '1;

  localparam int P4x4_00  = 0;
  localparam int P4x4_01  = 1;
  localparam int P4x4_02  = 2;
  localparam int P4x4_03  = 3;
  localparam int P4x4_10  = 4;
  localparam int P4x4_11  = 5;
  localparam int P4x4_12  = 6;
  localparam int P4x4_13  = 7;
  localparam int P4x4_20  = 8;
  localparam int P4x4_21  = 9;
  localparam int P4x4_22  = 10;
  localparam int P4x4_23  = 11;
  localparam int P4x4_30  = 12;
  localparam int P4x4_31  = 13;
  localparam int P4x4_32  = 14;
  localparam int P4x4_33  = 15;
  localparam int P4x8_00  = 16;
  localparam int P4x8_01  = 17;
  localparam int P4x8_02  = 18;
  localparam int P4x8_03  = 19;
  localparam int P4x8_10  = 20;
  localparam int P4x8_11  = 21;
  localparam int P4x8_12  = 22;
  localparam int P4x8_13  = 23;
  localparam int P8x4_00  = 24;
  localparam int P8x4_10  = 25;
  localparam int P8x4_20  = 26;
  localparam int P8x4_30  = 27;
  localparam int P8x4_01  = 28;
  localparam int P8x4_11  = 29;
  localparam int P8x4_21  = 30;
  localparam int P8x4_31  = 31;
  localparam int P8x8_00  = 32;
  localparam int P8x8_10  = 33;
  localparam int P8x8_01  = 34;
  localparam int P8x8_11  = 35;
  localparam int P16x8_0  = 36;
  localparam int P16x8_1  = 37;
  localparam int P8x16_0  = 38;
  localparam int P8x16_1  = 39;
  localparam int P16x16   = 40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sad_min_select_if.sv
// SAD-set input stream and per-partition best-result outputs of sad_min_select.
`default_nettype none

interface sad_min_select_if;
  import h264_inter_pkg::*;

  logic start;
  logic sad_valid;
  sad_t sad_in   [NPART];
  logic busy;
  logic done;
  sad_t best_sad [NPART];
  mv_t  best_mvx [NPART];
  mv_t  best_mvy [NPART];

  modport master (
    output start, sad_valid, sad_in,
    input  busy, done, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output busy, done, best_sad, best_mvx, best_mvy
  );

endinterface

`default_nettype wire

// File: rtl/min_cmp_unit.sv
// Running-minimum register for one partition: strict compare keeps the raster-first
// position on ties; clear re-arms it for a new search pass.
`default_nettype none

module min_cmp_unit
  import h264_inter_pkg::*;
#(
  parameter mv_t MV_INIT = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic accept,
  input  sad_t sad_in,
  input  mv_t  cur_x,
  input  mv_t  cur_y,
  output sad_t best_sad,
  output mv_t  best_mvx,
  output mv_t  best_mvy
);

  logic update;

  assign update = accept && (sad_in < best_sad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_sad <= SAD_MAX;
      best_mvx <= '0;
      best_mvy <= '0;
    end else if (clear) begin
      best_sad <= SAD_MAX;
      best_mvx <= MV_INIT;
      best_mvy <= MV_INIT;
    end else if (update) begin
      best_sad <= sad_in;
      best_mvx <= cur_x;
      best_mvy <= cur_y;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sad_min_select.sv
// Full-search minimum-SAD tracker: walks the search window in raster order and keeps
// the best SAD and motion vector for each of the 41 H.264 partitions.
`default_nettype none

module sad_min_select
  import h264_inter_pkg::*;
#(
  parameter int SRCH_R = 16
) (
  input  logic             clk,
  input  logic             rst,
  sad_min_select_if.slave  bus
);

  localparam mv_t MV_LO = mv_t'(-SRCH_R);
  localparam mv_t MV_HI = mv_t'(SRCH_R - 1);

  state_t state;
  state_t state_nxt;
  logic   clear;
  logic   accept;
  logic   last;
  mv_t    cur_x;
  mv_t    cur_y;

  assign accept = (state == SEARCH) && bus.sad_valid;
  assign last   = (cur_x == MV_HI) && (cur_y == MV_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SEARCH;
          clear     = 1'b1;
        end
      end
      SEARCH: begin
        if (accept && last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster walk, x fastest; the wrap after the last position is harmless since
  // the next start reloads both counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_x <= MV_LO;
      cur_y <= MV_LO;
    end else if (clear) begin
      cur_x <= MV_LO;
      cur_y <= MV_LO;
    end else if (accept) begin
      if (cur_x == MV_HI) begin
        cur_x <= MV_LO;
        cur_y <= (cur_y == MV_HI) ? MV_LO : cur_y + mv_t'(1);
      end else begin
        cur_x <= cur_x + mv_t'(1);
      end
    end
  end

  assign bus.busy = (state == SEARCH);
  assign bus.done = (state == DONE);

  generate
    for (genvar p = 0; p < NPART; p++) begin : g_part
      min_cmp_unit #(
        .MV_INIT (MV_LO)
      ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .accept   (accept),
        .sad_in   (bus.sad_in[p]),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .best_sad (bus.best_sad[p]),
        .best_mvx (bus.best_mvx[p]),
        .best_mvy (bus.best_mvy[p])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sad_min_select.sv
// Bench for sad_min_select: small-window DUT checked every cycle against a sample-count
// model, plus a full-size window smoke run checked at completion.
`default_nettype none

module tb_sad_min_select;
  import h264_inter_pkg::*;

  localparam int R  = 2;
  localparam int N  = (2*R)*(2*R);
  localparam int RB = 16;
  localparam int NB = (2*RB)*(2*RB);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  sad_min_select_if sif ();
  sad_min_select_if bif ();

  sad_min_select #(.SRCH_R(R))  u_dut  (.clk(clk), .rst(rst), .bus(sif));
  sad_min_select #(.SRCH_R(RB)) u_big  (.clk(clk), .rst(rst), .bus(bif));

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad < 40) $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic mv_t px(input int pos);
    return mv_t'(pos % (2*R) - R);
  endfunction
  function automatic mv_t py(input int pos);
    return mv_t'(pos / (2*R) - R);
  endfunction

  // Behavioural model: a pass is N accepted samples; sample k sits at raster position k.
  sad_t m_sad [NPART];
  mv_t  m_x   [NPART];
  mv_t  m_y   [NPART];
  int   m_pos;
  bit   m_search;
  bit   m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_search <= 1'b0;
      m_done   <= 1'b0;
      m_pos    <= 0;
      for (int p = 0; p < NPART; p++) begin
        m_sad[p] <= '1;
        m_x[p]   <= '0;
        m_y[p]   <= '0;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_search) begin
      if (sif.start) begin
        m_search <= 1'b1;
        m_pos    <= 0;
        for (int p = 0; p < NPART; p++) begin
          m_sad[p] <= '1;
          m_x[p]   <= mv_t'(-R);
          m_y[p]   <= mv_t'(-R);
        end
      end
    end else if (sif.sad_valid) begin
      for (int p = 0; p < NPART; p++) begin
        if (sif.sad_in[p] < m_sad[p]) begin
          m_sad[p] <= sif.sad_in[p];
          m_x[p]   <= px(m_pos);
          m_y[p]   <= py(m_pos);
        end
      end
      m_pos <= m_pos + 1;
      if (m_pos == N-1) begin
        m_search <= 1'b0;
        m_done   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (sif.done === 1'b1) n_done++;
    chk("busy", sif.busy, m_search);
    chk("done", sif.done, m_done);
    for (int p = 0; p < NPART; p++) begin
      chk($sformatf("sad[%0d]", p), sif.best_sad[p], m_sad[p]);
      chk($sformatf("mvx[%0d]", p), sif.best_mvx[p], m_x[p]);
      chk($sformatf("mvy[%0d]", p), sif.best_mvy[p], m_y[p]);
    end
  end

  sad_t pat [N][NPART];

  task automatic fill_const(input sad_t v);
    for (int k = 0; k < N; k++)
      for (int p = 0; p < NPART; p++) pat[k][p] = v;
  endtask

  task automatic fill_rand(input int maxv);
    for (int k = 0; k < N; k++)
      for (int p = 0; p < NPART; p++) pat[k][p] = sad_t'($urandom_range(0, maxv));
  endtask

  // stall: 0 none, 1 alternate 1010.., 2 random. dup_at: sample index at which start is
  // re-pulsed during SEARCH (-1 none). abort_at: stop feeding after this many samples.
  task automatic run_pass(input int stall, input int dup_at, input int abort_at);
    int  pos = 0;
    int  cyc = 0;
    bit  v;
    bit  tog = 1'b1;
    @(negedge clk);
    sif.start     = 1'b1;
    sif.sad_valid = 1'($urandom_range(0, 1));
    for (int p = 0; p < NPART; p++) sif.sad_in[p] = '0;
    while (pos < N && pos != abort_at && cyc < 400) begin
      @(negedge clk);
      if (cyc > 0 && v) pos++;
      if (pos == N || pos == abort_at) break;
      case (stall)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      sif.start     = (dup_at >= 0 && pos == dup_at && v);
      sif.sad_valid = v;
      for (int p = 0; p < NPART; p++) sif.sad_in[p] = pat[pos][p];
      cyc++;
    end
    sif.start     = 1'b0;
    sif.sad_valid = 1'b0;
    if (pos == abort_at) return;
    chk("pass_complete", pos, N);
    chk("done_time", sif.done, 1'b1);
    @(negedge clk);
    chk("done_width", sif.done, 1'b0);
  endtask

  sad_t s_sad [NPART];
  mv_t  s_x   [NPART];
  mv_t  s_y   [NPART];
  sad_t bs    [NPART];
  mv_t  bx    [NPART];
  mv_t  by    [NPART];

  initial begin
    int nd;
    sif.start = 1'b0; sif.sad_valid = 1'b0;
    bif.start = 1'b0; bif.sad_valid = 1'b0;
    for (int p = 0; p < NPART; p++) begin
      sif.sad_in[p] = '0;
      bif.sad_in[p] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", sif.busy, 1'b0);
    chk("rst_done", sif.done, 1'b0);
    chk("rst_sad0", sif.best_sad[0], 16'hFFFF);
    chk("rst_sad40", sif.best_sad[P16x16], 16'hFFFF);
    chk("rst_mvx", sif.best_mvx[7], 0);
    chk("rst_mvy", sif.best_mvy[7], 0);

    // Single low value at (1,-2) for the 16x16 partition.
    fill_const(sad_t'(100));
    pat[3][P16x16] = sad_t'(7);
    run_pass(0, -1, -1);
    chk("t2_sad40", sif.best_sad[P16x16], 7);
    chk("t2_mvx40", sif.best_mvx[P16x16], 1);
    chk("t2_mvy40", sif.best_mvy[P16x16], -2);
    chk("t2_sad0", sif.best_sad[0], 100);
    chk("t2_mvx0", sif.best_mvx[0], -2);
    chk("t2_mvy0", sif.best_mvy[0], -2);
    repeat (3) @(negedge clk);
    chk("t2_hold", sif.best_sad[P16x16], 7);

    // Tie: equal minima at (-1,-2) and (0,1); raster-first wins.
    fill_const(sad_t'(50));
    pat[1][0]  = sad_t'(5);
    pat[14][0] = sad_t'(5);
    run_pass(0, -1, -1);
    chk("t3_sad0", sif.best_sad[0], 5);
    chk("t3_mvx0", sif.best_mvx[0], -1);
    chk("t3_mvy0", sif.best_mvy[0], -2);

    // Stalled pass must match the unstalled one.
    fill_rand(31);
    run_pass(0, -1, -1);
    for (int p = 0; p < NPART; p++) begin
      s_sad[p] = sif.best_sad[p]; s_x[p] = sif.best_mvx[p]; s_y[p] = sif.best_mvy[p];
    end
    run_pass(1, -1, -1);
    for (int p = 0; p < NPART; p++) begin
      chk("t4_sad", sif.best_sad[p], s_sad[p]);
      chk("t4_mvx", sif.best_mvx[p], s_x[p]);
      chk("t4_mvy", sif.best_mvy[p], s_y[p]);
    end

    // Reset after 5 accepted samples: no done pulse, reset values, then a clean pass.
    fill_rand(31);
    nd = n_done;
    run_pass(0, -1, 5);
    #1 rst = 1'b0;
    #1;
    chk("t5_busy", sif.busy, 1'b0);
    chk("t5_sad", sif.best_sad[P16x16], 16'hFFFF);
    chk("t5_mvx", sif.best_mvx[P16x16], 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_nodone", n_done, nd);
    run_pass(0, -1, -1);
    chk("t5_donecount", n_done, nd + 1);

    // start re-pulsed mid-search is ignored.
    fill_rand(31);
    run_pass(0, 7, -1);

    // Randomised passes with idle-time noise on start/sad_valid.
    for (int it = 0; it < 8; it++) begin
      fill_rand(15);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        sif.sad_valid = 1'($urandom_range(0, 1));
        for (int p = 0; p < NPART; p++) sif.sad_in[p] = '0;
      end
      run_pass(2, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, N-1)) : -1, -1);
    end

    // Full-size window smoke run.
    for (int p = 0; p < NPART; p++) bs[p] = '1;
    @(negedge clk);
    bif.start = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      bif.start     = 1'b0;
      bif.sad_valid = 1'b1;
      for (int p = 0; p < NPART; p++) begin
        sad_t v;
        v = sad_t'($urandom_range(0, 4095));
        bif.sad_in[p] = v;
        if (v < bs[p]) begin
          bs[p] = v;
          bx[p] = mv_t'(k % (2*RB) - RB);
          by[p] = mv_t'(k / (2*RB) - RB);
        end
      end
    end
    @(negedge clk);
    bif.sad_valid = 1'b0;
    chk("big_done", bif.done, 1'b1);
    for (int p = 0; p < NPART; p++) begin
      chk("big_sad", bif.best_sad[p], bs[p]);
      chk("big_mvx", bif.best_mvx[p], bx[p]);
      chk("big_mvy", bif.best_mvy[p], by[p]);
    end
    @(negedge clk);
    chk("big_done_width", bif.done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
